// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, FSM encoding and byte-lane helpers for memory_access
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Big-endian lanes: bit 3 of the enable is byte 0 (bits 31:24).
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b1000 >> off;
            MEM_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            MEM_BYTE: wd = {4{data[7:0]}};
            MEM_HALF: wd = {2{data[15:0]}};
            default:  wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - big-endian lane select with sign/zero extension of load data
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];

        case (size)
            MEM_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM pipeline stage: data-memory handshake, load extension, writeback register
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module memory_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_val,
    input  logic [31:0] in_store_data,
    input  logic        mem_op,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_val,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_err
);

    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        store_q, store_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;

    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_val_q, wb_val_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_err_q, wb_err_d;

    logic        misaligned;
    logic [31:0] load_data;
    logic [8:0]  cnt_next;

    load_extend u_load_extend (
        .rdata       (dmem_rdata),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        case (mem_size)
            MEM_BYTE: misaligned = 1'b0;
            MEM_HALF: misaligned = in_val[0];
            default:  misaligned = (in_val[1:0] != 2'b00);
        endcase
`else
        misaligned = 1'b0;
`endif
    end

    assign cnt_next = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        size_d         = size_q;
        store_d        = store_q;
        uns_d          = uns_q;
        rd_d           = rd_q;
        rw_d           = rw_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_val_d       = wb_val_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_err_d       = wb_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_val_d       = in_val;
                        wb_rd_d        = in_rd;
                        wb_reg_write_d = in_reg_write;
                        wb_err_d       = 1'b0;
                    end else if (misaligned) begin
                        wb_valid_d     = 1'b1;
                        wb_val_d       = in_val;
                        wb_rd_d        = in_rd;
                        wb_reg_write_d = 1'b0;
                        wb_err_d       = 1'b1;
                    end else begin
                        state_d      = ST_REQ;
                        cnt_d        = 8'd0;
                        addr_d       = in_val;
                        size_d       = mem_size;
                        store_d      = mem_we;
                        uns_d        = mem_unsigned;
                        rd_d         = in_rd;
                        rw_d         = in_reg_write;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_we;
                        dmem_addr_d  = {in_val[31:2], 2'b00};
                        dmem_be_d    = lane_be(mem_size, in_val[1:0]);
                        dmem_wdata_d = lane_wdata(mem_size, in_store_data);
                    end
                end
            end
            ST_REQ: begin
                // An ack on the limit cycle wins over the timeout.
                if (dmem_ack) begin
                    state_d        = ST_IDLE;
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_val_d       = store_q ? addr_q : load_data;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = store_q ? 1'b0 : rw_q;
                    wb_err_d       = 1'b0;
                end else if (cnt_next >= TMO_LIMIT) begin
                    state_d        = ST_IDLE;
                    cnt_d          = cnt_next[7:0];
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_val_d       = addr_q;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = 1'b0;
                    wb_err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_next[7:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            addr_q         <= 32'd0;
            size_q         <= MEM_BYTE;
            store_q        <= 1'b0;
            uns_q          <= 1'b0;
            rd_q           <= 5'd0;
            rw_q           <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_be_q      <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_val_q       <= 32'd0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            store_q        <= store_d;
            uns_q          <= uns_d;
            rd_q           <= rd_d;
            rw_q           <= rw_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_val_q       <= wb_val_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_val       = wb_val_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed vector bench for memory_access (TIMEOUT_CYCLES = 4)
module tb_memory_access;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_val;
    logic [31:0] in_store_data;
    logic        mem_op;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_val;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_err;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_val        (in_val),
        .in_store_data (in_store_data),
        .mem_op        (mem_op),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_val        (wb_val),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_err        (wb_err)
    );

    // kind: 0 = ALU passthrough, 1 = memory op, 2 = misaligned (error, no request)
    typedef struct {
        int          kind;
        logic [31:0] val;
        logic [31:0] sdata;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_rw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int kind, logic [31:0] val, logic [31:0] sdata, logic we,
                                logic [1:0] size, logic uns, logic [4:0] rd, logic rw,
                                logic [31:0] rdata, int waits, logic [31:0] e_addr,
                                logic [3:0] e_be, logic [31:0] e_wdata, logic [31:0] e_wb,
                                logic e_rw);
        vec_t v;
        v.kind = kind; v.val = val; v.sdata = sdata; v.we = we; v.size = size;
        v.uns = uns; v.rd = rd; v.rw = rw; v.rdata = rdata; v.waits = waits;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_val = 32'd0; in_store_data = 32'd0; mem_op = 1'b0;
        mem_we = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0; in_rd = 5'd0;
        in_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        in_valid = 1'b1; in_val = v.val; in_store_data = v.sdata; mem_op = (v.kind != 0);
        mem_we = v.we; mem_size = v.size; mem_unsigned = v.uns; in_rd = v.rd;
        in_reg_write = v.rw;
        tick();
        in_valid = 1'b0;
        if (v.kind == 1) begin
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'd1);
            chk({tag, " dmem_addr"}, dmem_addr, v.e_addr);
            chk({tag, " dmem_be"}, 32'(dmem_be), 32'(v.e_be));
            chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.we));
            if (v.we) chk({tag, " dmem_wdata"}, dmem_wdata, v.e_wdata);
            chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            for (int w = 0; w < v.waits; w++) begin
                tick();
                chk({tag, " req held"}, 32'({dmem_req, wb_valid}), 32'b10);
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            tick();
            dmem_ack = 1'b0; dmem_rdata = 32'd0;
            chk({tag, " dmem_req drop"}, 32'(dmem_req), 32'd0);
        end
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, " wb_val"}, wb_val, v.e_wb);
        chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({tag, " wb_reg_write"}, 32'(wb_reg_write), 32'(v.e_rw));
        chk({tag, " wb_err"}, 32'(wb_err), 32'(v.kind == 2));
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        if (v.kind != 1) chk({tag, " no req"}, 32'(dmem_req), 32'd0);
        tick();
        chk({tag, " wb_valid pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        int n;
        int reqc;
        logic saw_wb;

        // ALU, lb/lbu, sh, lh/lhu, lw, sb, lb positive, lw misaligned, size 3, ack on limit cycle
        vecs.push_back(mk(0, 32'h1234_5678, 0, 0, 2'd2, 0, 5'd5, 1, 0, 0, 0, 0, 0, 32'h1234_5678, 1));
        vecs.push_back(mk(1, 32'h0000_0101, 0, 0, 2'd0, 0, 5'd7, 1, 32'h00F0_0000, 2, 32'h100, 4'b0100, 0, 32'hFFFF_FFF0, 1));
        vecs.push_back(mk(1, 32'h0000_0101, 0, 0, 2'd0, 1, 5'd7, 1, 32'h00F0_0000, 2, 32'h100, 4'b0100, 0, 32'h0000_00F0, 1));
        vecs.push_back(mk(1, 32'h0000_0202, 32'h0000_ABCD, 1, 2'd1, 0, 5'd3, 1, 0, 0, 32'h200, 4'b0011, 32'hABCD_ABCD, 32'h202, 0));
        vecs.push_back(mk(1, 32'h0000_0200, 0, 0, 2'd1, 0, 5'd9, 1, 32'h8001_1234, 0, 32'h200, 4'b1100, 0, 32'hFFFF_8001, 1));
        vecs.push_back(mk(1, 32'h0000_0202, 0, 0, 2'd1, 1, 5'd9, 1, 32'h8001_9234, 1, 32'h200, 4'b0011, 0, 32'h0000_9234, 1));
        vecs.push_back(mk(1, 32'h0000_0204, 0, 0, 2'd2, 0, 5'd31, 1, 32'hDEAD_BEEF, 1, 32'h204, 4'b1111, 0, 32'hDEAD_BEEF, 1));
        vecs.push_back(mk(1, 32'h0000_0103, 32'h1234_56A5, 1, 2'd0, 0, 5'd2, 0, 0, 0, 32'h100, 4'b0001, 32'hA5A5_A5A5, 32'h103, 0));
        vecs.push_back(mk(1, 32'h0000_0102, 0, 0, 2'd0, 0, 5'd4, 1, 32'h0000_7F00, 0, 32'h100, 4'b0010, 0, 32'h0000_007F, 1));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(2, 32'h0000_0203, 0, 0, 2'd2, 0, 5'd6, 1, 0, 0, 0, 0, 0, 32'h203, 0));
`else
        vecs.push_back(mk(1, 32'h0000_0203, 0, 0, 2'd2, 0, 5'd6, 1, 32'h0102_0304, 0, 32'h200, 4'b1111, 0, 32'h0102_0304, 1));
`endif
        vecs.push_back(mk(1, 32'h0000_0300, 32'hCAFE_F00D, 1, 2'd3, 0, 5'd1, 0, 0, 0, 32'h300, 4'b1111, 32'hCAFE_F00D, 32'h300, 0));
        vecs.push_back(mk(1, 32'h0000_0208, 0, 0, 2'd2, 0, 5'd8, 1, 32'h0102_0304, 3, 32'h208, 4'b1111, 0, 32'h0102_0304, 1));
        vecs.push_back(mk(0, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0));

        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset outs", 32'({dmem_req, dmem_we, wb_valid, wb_reg_write, wb_err}), 32'd0);
        chk("reset dmem_addr", dmem_addr, 32'd0);
        chk("reset dmem_be", 32'(dmem_be), 32'd0);
        chk("reset dmem_wdata", dmem_wdata, 32'd0);
        chk("reset wb_val", wb_val, 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Stray ack while idle must not produce a writeback
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        tick();
        dmem_ack = 1'b0;
        chk("idle ack ignored", 32'({wb_valid, dmem_req, in_ready}), 32'b001);

        // Timeout with no ack: request held for exactly TIMEOUT_CYCLES cycles
        in_valid = 1'b1; in_val = 32'h0000_0400; mem_op = 1'b1; mem_we = 1'b0;
        mem_size = 2'd2; mem_unsigned = 1'b0; in_rd = 5'd12; in_reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0; reqc = 0;
        while (!wb_valid && n < 20) begin
            if (dmem_req) reqc++;
            tick();
            n++;
        end
        chk("tmo wb_valid", 32'(wb_valid), 32'd1);
        chk("tmo req cycles", 32'(reqc), 32'd4);
        chk("tmo wb_err", 32'(wb_err), 32'd1);
        chk("tmo wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("tmo dmem_req", 32'(dmem_req), 32'd0);
        chk("tmo in_ready", 32'(in_ready), 32'd1);
        tick();

        // Asynchronous reset while a request is outstanding
        in_valid = 1'b1; in_val = 32'h0000_0500; mem_op = 1'b1; mem_we = 1'b1;
        mem_size = 2'd2; in_store_data = 32'h1111_2222; in_rd = 5'd13; in_reg_write = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rst pre req", 32'(dmem_req), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst async req", 32'(dmem_req), 32'd0);
        chk("rst async ready", 32'(in_ready), 32'd1);
        saw_wb = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (wb_valid) saw_wb = 1'b1;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wb_valid || dmem_req) saw_wb = 1'b1;
        end
        chk("rst no wb", 32'(saw_wb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
